// File: rtl/fourbit_serial_subtractor_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: operand width and FSM encodings.
package fourbit_serial_subtractor_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/fourbit_serial_subtractor_if.sv
// Operand/result handshake bundle between the operand registers and the serial subtractor.
interface fourbit_serial_subtractor_if;
    import fourbit_serial_subtractor_pkg::*;

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout, Ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout, Ovf
    );

endinterface

// File: rtl/fullsubtractor.sv
// Single-bit full subtractor; port order mirrors the full-adder cell.
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic bout,
    output logic d
);

    // Difference and borrow-out of a - b - bin
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/fourbit_serial_subtractor.sv
// Bit-serial 4-bit subtractor: Diff = A - B - Bin, one bit per clock through one cell.
module fourbit_serial_subtractor
    import fourbit_serial_subtractor_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    fourbit_serial_subtractor_if.slave    bus
);

    logic [ST_W-1:0]  state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic cell_d;
    logic cell_bout;

    fullsubtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .bout (cell_bout),
        .d    (cell_d)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, shift datapath and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.A;
                    b_sh_d   = bus.B;
                    borrow_d = bus.Bin;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_d    = {cell_d, res_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // borrow_q here is the borrow into the sign bit
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = borrow_q ^ cell_bout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Drive the bus from registered outputs
    always_comb begin
        bus.busy = busy_q;
        bus.done = done_q;
        bus.Diff = diff_q;
        bus.Bout = bout_q;
        bus.Ovf  = ovf_q;
    end

endmodule

// File: tb/tb_fourbit_serial_subtractor.sv
// Scoreboard bench for the bit-serial subtractor: stimulus pushes expectations, monitor pops on done.
module tb_fourbit_serial_subtractor;

    typedef struct {
        logic [3:0]  diff;
        logic        bout;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          checks;
    int          errors;
    exp_t        sb_q[$];

    fourbit_serial_subtractor_if dut_if ();

    fourbit_serial_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input logic bo, input logic ov, input int unsigned c);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    // Drive one operation from IDLE and wait until the block is back in IDLE
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input logic [3:0] ed, input logic ebo, input logic eov);
        int unsigned k;
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.A     = a;
        dut_if.B     = b;
        dut_if.Bin   = bin;
        @(posedge clk); #1;
        k = cyc;
        push_exp(ed, ebo, eov, k + 4);
        check("busy_after_start", 32'(dut_if.busy), 32'd1);
        @(negedge clk);
        dut_if.start = 1'b0;
        dut_if.A     = ~a;
        dut_if.B     = ~b;
        dut_if.Bin   = ~bin;
        repeat (5) @(posedge clk);
        #1;
        check("busy_back_idle", 32'(dut_if.busy), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest expectation and its cycle
    always @(negedge clk) begin
        if (!rst && dut_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff",    32'(dut_if.Diff), 32'(e.diff));
                check("bout",    32'(dut_if.Bout), 32'(e.bout));
                check("ovf",     32'(dut_if.Ovf),  32'(e.ovf));
                check("latency", cyc,              e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        dut_if.start = 1'b0;
        dut_if.A     = 4'h0;
        dut_if.B     = 4'h0;
        dut_if.Bin   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(dut_if.busy), 32'd0);
        check("rst_done", 32'(dut_if.done), 32'd0);
        check("rst_diff", 32'(dut_if.Diff), 32'd0);
        check("rst_bout", 32'(dut_if.Bout), 32'd0);
        check("rst_ovf",  32'(dut_if.Ovf),  32'd0);
        rst = 1'b0;

        // 9-3: as signed, -7 - 3 = -10 overflows
        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1);
        run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
        run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        run_op(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1);

        // Start re-pulsed during SHIFT must be ignored; Diff holds 0x7 until completion
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.A     = 4'd7;
        dut_if.B     = 4'd2;
        dut_if.Bin   = 1'b0;
        @(posedge clk); #1;
        k = cyc;
        push_exp(4'h5, 1'b0, 1'b0, k + 4);
        @(negedge clk);
        dut_if.start = 1'b0;
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.A     = 4'd1;
        dut_if.B     = 4'd6;
        dut_if.Bin   = 1'b1;
        @(posedge clk); #1;
        check("busy_in_shift", 32'(dut_if.busy), 32'd1);
        check("diff_held_k2",  32'(dut_if.Diff), 32'h7);
        @(negedge clk);
        dut_if.start = 1'b0;
        @(posedge clk); #1;
        check("diff_held_k3",  32'(dut_if.Diff), 32'h7);
        repeat (2) @(posedge clk);
        #1;
        check("repulse_idle", 32'(dut_if.busy), 32'd0);
        repeat (8) @(negedge clk);
        check("no_second_op", 32'(dut_if.busy), 32'd0);

        // Reset two cycles into SHIFT clears outputs asynchronously
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.A     = 4'd6;
        dut_if.B     = 4'd1;
        dut_if.Bin   = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        dut_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(dut_if.busy), 32'd0);
        check("arst_done", 32'(dut_if.done), 32'd0);
        check("arst_diff", 32'(dut_if.Diff), 32'd0);
        check("arst_bout", 32'(dut_if.Bout), 32'd0);
        check("arst_ovf",  32'(dut_if.Ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 1'b0);

        // Start held high: re-accepted every 6 cycles (10-3-1 = 6, signed -6-3-1 overflows)
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.A     = 4'hA;
        dut_if.B     = 4'h3;
        dut_if.Bin   = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        push_exp(4'h6, 1'b0, 1'b1, k + 4);
        push_exp(4'h6, 1'b0, 1'b1, k + 10);
        repeat (6) @(posedge clk);
        #1;
        check("reaccept_busy", 32'(dut_if.busy), 32'd1);
        @(negedge clk);
        dut_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("held_idle", 32'(dut_if.busy), 32'd0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
